demux2_reg: RTL and testbench

- Registered 1-to-2 demultiplexer: one producer stream is steered to one of two consumer ports, selected per transfer.
- Inverse of the datapath 2-way selectors; used where one result (ALU/memory value, 64-bit, or 6-bit register index) fans out to two destinations.
- One-entry pipeline stage with valid/ready handshake on both sides, so full throughput with 1-cycle latency.

---
 rtl/demux2_reg_pkg.sv | 14 +
 rtl/demux2_reg_if.sv | 29 ++
 rtl/demux2_reg.sv | 99 +++++++++
 tb/tb_demux2_reg.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux2_reg_pkg.sv
// Shared encodings for the registered 1-to-2 demultiplexer.
package demux2_reg_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   localparam logic SEL_P0 = 1'b0;
   localparam logic SEL_P1 = 1'b1;

   localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/demux2_reg_if.sv
// Producer-side and two consumer-side valid/ready channels of demux2_reg.
interface demux2_reg_if #(
   parameter int WIDTH = 64
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;

   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out0_data;

   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;

   modport master (
      output in_valid, in_data, in_sel, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data
   );

   modport slave (
      input  in_valid, in_data, in_sel, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data
   );

endinterface

// File: rtl/demux2_reg.sv
// One-entry registered 1-to-2 demultiplexer with valid/ready on both sides.
// Define DEMUX2_STATS_EN to add per-port output transfer counters cnt0/cnt1.
module demux2_reg
   import demux2_reg_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic                clk,
   input  logic                reset,
   demux2_reg_if.slave         bus
`ifdef DEMUX2_STATS_EN
   ,
   output logic [STATS_W-1:0]  cnt0,
   output logic [STATS_W-1:0]  cnt1
`endif
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_q, sel_d;
   logic             drain;
   logic             in_xfer;

   // Only the selected port's ready can free the entry; the other is ignored.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;

      drain        = (state_q == ST_FULL) &&
                     ((sel_q == SEL_P1) ? bus.out1_ready : bus.out0_ready);
      bus.in_ready = (state_q == ST_EMPTY) || drain;
      in_xfer      = bus.in_valid && bus.in_ready;

      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_d = ST_FULL;
               data_d  = bus.in_data;
               sel_d   = bus.in_sel;
            end
         end
         ST_FULL: begin
            if (in_xfer) begin
               data_d = bus.in_data;
               sel_d  = bus.in_sel;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         sel_q   <= SEL_P0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   assign bus.out0_valid = (state_q == ST_FULL) && (sel_q == SEL_P0);
   assign bus.out1_valid = (state_q == ST_FULL) && (sel_q == SEL_P1);
   assign bus.out0_data  = data_q;
   assign bus.out1_data  = data_q;

`ifdef DEMUX2_STATS_EN
   logic [STATS_W-1:0] cnt0_q, cnt0_d;
   logic [STATS_W-1:0] cnt1_q, cnt1_d;

   // Counters wrap naturally at the top of their range.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (bus.out0_valid && bus.out0_ready) cnt0_d = cnt0_q + STATS_W'(1);
      if (bus.out1_valid && bus.out1_ready) cnt1_d = cnt1_q + STATS_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_reg.sv
// Self-checking bench for demux2_reg: directed scenarios plus a per-port scoreboard.
module tb_demux2_reg;
   import demux2_reg_pkg::*;

   localparam int WIDTH = 64;

   logic clk;
   logic reset;

   demux2_reg_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX2_STATS_EN
   logic [STATS_W-1:0] cnt0, cnt1;
`endif

   demux2_reg #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DEMUX2_STATS_EN
      ,
      .cnt0  (cnt0),
      .cnt1  (cnt1)
`endif
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int deliv0       = 0;
   int deliv1       = 0;

   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard: inputs are queued per destination when accepted; outputs pop and compare.
   always @(negedge clk) begin
      logic [WIDTH-1:0] exp;
      if (reset) begin
         q0.delete();
         q1.delete();
         deliv0 = 0;
         deliv1 = 0;
      end else begin
         tests_run++;
         if (bus.out0_valid && bus.out1_valid) begin
            tests_failed++;
            $display("FAIL both_valid: out0_valid=%b out1_valid=%b, expected at most one", bus.out0_valid, bus.out1_valid);
         end
         if (bus.out0_valid && bus.out0_ready) begin
            tests_run++;
            deliv0++;
            if (q0.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_port0: unexpected delivery %0h, expected none", bus.out0_data);
            end else begin
               exp = q0.pop_front();
               if (bus.out0_data !== exp) begin
                  tests_failed++;
                  $display("FAIL sb_port0: got %0h expected %0h", bus.out0_data, exp);
               end
            end
         end
         if (bus.out1_valid && bus.out1_ready) begin
            tests_run++;
            deliv1++;
            if (q1.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_port1: unexpected delivery %0h, expected none", bus.out1_data);
            end else begin
               exp = q1.pop_front();
               if (bus.out1_data !== exp) begin
                  tests_failed++;
                  $display("FAIL sb_port1: got %0h expected %0h", bus.out1_data, exp);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            if (bus.in_sel) q1.push_back(bus.in_data);
            else            q0.push_back(bus.in_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_drained(input string name);
      tests_run++;
      if (q0.size() != 0 || q1.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_drained: pending q0=%0d q1=%0d, expected 0 0", name, q0.size(), q1.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 64'hDEAD_BEEF_0000_1111;
      bus.in_sel   = 1'b1;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      tick();
      tick();
      tests_run++;
      if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid: out0_valid=%b out1_valid=%b, expected 0 0", bus.out0_valid, bus.out1_valid);
      end
      tests_run++;
      if (bus.out0_data !== '0 || bus.out1_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: out0=%0h out1=%0h, expected 0 0", bus.out0_data, bus.out1_data);
      end
      reset = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
`ifdef DEMUX2_STATS_EN
      tests_run++;
      if (cnt0 !== '0 || cnt1 !== '0) begin
         tests_failed++;
         $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d, expected 0 0", cnt0, cnt1);
      end
`endif
   endtask

   task automatic test_single();
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b1;
      bus.in_data  = 64'h0123_4567_89AB_CDEF;
      bus.in_sel   = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tests_run++;
      if (bus.out1_valid !== 1'b1 || bus.out0_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_valid: out0_valid=%b out1_valid=%b, expected 0 1", bus.out0_valid, bus.out1_valid);
      end
      tests_run++;
      if (bus.out1_data !== 64'h0123_4567_89AB_CDEF || bus.out0_data !== 64'h0123_4567_89AB_CDEF) begin
         tests_failed++;
         $display("FAIL single_data: out1=%0h out0=%0h, expected 123456789abcdef on both", bus.out1_data, bus.out0_data);
      end
      tick();
      tests_run++;
      if (bus.out1_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_empty: out1_valid=%b in_ready=%b, expected 0 1", bus.out1_valid, bus.in_ready);
      end
      check_drained("single");
   endtask

   task automatic test_backpressure();
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b1;
      bus.in_data  = 64'hAA;
      bus.in_sel   = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data = 64'hBB;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (bus.out0_valid !== 1'b1 || bus.out0_data !== 64'hAA || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%0h in_ready=%b, expected 1 aa 0", i, bus.out0_valid, bus.out0_data, bus.in_ready);
         end
         tick();
      end
      bus.out0_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tests_run++;
      if (bus.out0_valid !== 1'b1 || bus.out0_data !== 64'hBB) begin
         tests_failed++;
         $display("FAIL bp_second: valid=%b data=%0h, expected 1 bb", bus.out0_valid, bus.out0_data);
      end
      tick();
      tick();
      tests_run++;
      if (bus.out0_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_empty: out0_valid=%b expected 0", bus.out0_valid);
      end
      check_drained("bp");
   endtask

   task automatic test_throughput();
      do_reset();
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         bus.in_data  = WIDTH'(i);
         bus.in_sel   = (i % 2 == 0);
         bus.in_valid = 1'b1;
         #1;
         tests_run++;
         if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL tput_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
         end
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      tick();
      tests_run++;
      if (deliv0 != 4 || deliv1 != 4) begin
         tests_failed++;
         $display("FAIL tput_count: port0=%0d port1=%0d, expected 4 4", deliv0, deliv1);
      end
`ifdef DEMUX2_STATS_EN
      tests_run++;
      if (cnt0 !== 32'd4 || cnt1 !== 32'd4) begin
         tests_failed++;
         $display("FAIL tput_cnt: cnt0=%0d cnt1=%0d, expected 4 4", cnt0, cnt1);
      end
`endif
      check_drained("tput");
   endtask

   task automatic test_nonsel_ready();
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b0;
      bus.in_data  = 64'h77;
      bus.in_sel   = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data = 64'h99;
      bus.in_sel  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (bus.in_ready !== 1'b0 || bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b1 || bus.out1_data !== 64'h77) begin
            tests_failed++;
            $display("FAIL nonsel[%0d]: in_ready=%b v0=%b v1=%b d1=%0h, expected 0 0 1 77", i, bus.in_ready, bus.out0_valid, bus.out1_valid, bus.out1_data);
         end
         tick();
      end
      bus.out1_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tests_run++;
      if (bus.out0_valid !== 1'b1 || bus.out0_data !== 64'h99) begin
         tests_failed++;
         $display("FAIL nonsel_switch: v0=%b d0=%0h, expected 1 99", bus.out0_valid, bus.out0_data);
      end
      tick();
      tick();
      check_drained("nonsel");
   endtask

   task automatic test_reset_mid();
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b1;
      bus.in_data  = 64'h55;
      bus.in_sel   = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tests_run++;
      if (bus.out0_valid !== 1'b1 || bus.out0_data !== 64'h55) begin
         tests_failed++;
         $display("FAIL rmid_full: v0=%b d0=%0h, expected 1 55", bus.out0_valid, bus.out0_data);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if (bus.out0_valid !== 1'b0 || bus.out0_data !== '0) begin
         tests_failed++;
         $display("FAIL rmid_cleared: v0=%b d0=%0h, expected 0 0", bus.out0_valid, bus.out0_data);
      end
      bus.out0_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (bus.out0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_never[%0d]: v0=%b expected 0", i, bus.out0_valid);
         end
      end
`ifdef DEMUX2_STATS_EN
      tests_run++;
      if (cnt0 !== '0 || cnt1 !== '0) begin
         tests_failed++;
         $display("FAIL rmid_cnt: cnt0=%0d cnt1=%0d, expected 0 0", cnt0, cnt1);
      end
`endif
      check_drained("rmid");
   endtask

   initial begin
      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_sel     = 1'b0;
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;

      test_reset();
      test_single();
      test_backpressure();
      test_throughput();
      test_nonsel_ready();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
